bk_sys_timer: RTL and testbench

- Programmable system timer, mapped as a bus responder on the inverted multiplexed MPI bus driven by the K1801VM1 CPU.
- Three registers in the BK-0011M timer window: reload, counter and control/status.
- Decrements a 16-bit counter on prescaled clock ticks and flags expiry.
- Expiry optionally raises an active-low interrupt request, intended for irq_n[3].

---
 rtl/bk_bus_pkg.sv | 39 +++
 rtl/bk_timer_core.sv | 129 ++++++++++++
 rtl/bk_sys_timer.sv | 169 ++++++++++++++++
 tb/tb_bk_sys_timer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bk_bus_pkg.sv
// rtl/bk_bus_pkg.sv - shared MPI responder definitions: register map, CSR bits, bus FSM states
package bk_bus_pkg;

   // Word offsets inside the timer window (ADDR[15:1] - BASE[15:1])
   localparam logic [1:0] REG_RELOAD = 2'd0;
   localparam logic [1:0] REG_COUNT  = 2'd1;
   localparam logic [1:0] REG_CSR    = 2'd2;

   // Control/status bit positions
   localparam int CSR_WRAP     = 0;
   localparam int CSR_IE       = 2;
   localparam int CSR_ONESHOT  = 3;
   localparam int CSR_RUN      = 4;
   localparam int CSR_PRESC_LO = 5;
   localparam int CSR_PRESC_HI = 6;
   localparam int CSR_EXP      = 7;

   // Prescaler multiplier table, indexed by CSR PRESC field
   function automatic int unsigned presc_mult(input logic [1:0] presc);
      case (presc)
         2'b00:   return 1;
         2'b01:   return 16;
         2'b10:   return 4;
         default: return 64;
      endcase
   endfunction

   // Bus cycle states common to MPI responders
   typedef enum logic [2:0] {
      BUS_IDLE,
      BUS_ADDR,
      BUS_RD_WAIT,
      BUS_RD_REPLY,
      BUS_WR_WAIT,
      BUS_WR_REPLY,
      BUS_END
   } bus_state_t;

endpackage

// File: rtl/bk_timer_core.sv
// rtl/bk_timer_core.sv - timer prescaler, down counter and CSR update logic
module bk_timer_core
   import bk_bus_pkg::*;
#(
   parameter int unsigned BASE_DIV = 128
) (
   input  logic        pin_clk,
   input  logic        pin_init_n,
   input  logic        wr_en,
   input  logic [1:0]  wr_reg,
   input  logic [15:0] wr_data,
   input  logic [1:0]  wr_be,
   output logic [15:0] reload,
   output logic [15:0] counter,
   output logic [7:0]  csr,
   output logic        irq_n
);

   // Wide enough for the largest division ratio (x64)
   localparam int unsigned PW = $clog2(BASE_DIV * 64);

   logic [15:0]   reload_q, reload_nxt;
   logic [15:0]   cnt_q, cnt_nxt;
   logic [15:0]   reload_wr;
   logic [7:0]    csr_q, csr_nxt;
   logic [PW-1:0] presc_q, presc_nxt;
   logic [PW-1:0] presc_term;
   logic          tick;
   logic          expire;
   logic          irq_q;

   assign presc_term = PW'(BASE_DIV * presc_mult(csr_q[CSR_PRESC_HI:CSR_PRESC_LO]) - 1);
   assign tick       = csr_q[CSR_RUN] && (presc_q == presc_term);

   // Reload value after merging the enabled byte lanes of a write
   assign reload_wr = {wr_be[1] ? wr_data[15:8] : reload_q[15:8],
                       wr_be[0] ? wr_data[7:0]  : reload_q[7:0]};

   // Next-state of all timer registers; bus writes applied after tick effects, expiry EXP set last
   always_comb begin
      reload_nxt = reload_q;
      cnt_nxt    = cnt_q;
      csr_nxt    = csr_q;
      presc_nxt  = presc_q;
      expire     = 1'b0;

      if (csr_q[CSR_RUN]) begin
         presc_nxt = tick ? '0 : presc_q + PW'(1);
      end

      if (tick) begin
         if (cnt_q != 16'd0) begin
            cnt_nxt = cnt_q - 16'd1;
         end else begin
            expire = 1'b1;
            if (csr_q[CSR_ONESHOT]) begin
               csr_nxt[CSR_RUN] = 1'b0;
               cnt_nxt          = 16'd0;
            end else if (csr_q[CSR_WRAP]) begin
               cnt_nxt = 16'hFFFF;
            end else if (wr_en && wr_reg == REG_RELOAD) begin
               // A reload written on the expiry cycle is the one that gets loaded
               cnt_nxt = reload_wr;
            end else begin
               cnt_nxt = reload_q;
            end
         end
      end

      if (wr_en) begin
         case (wr_reg)
            REG_RELOAD: reload_nxt = reload_wr;
            REG_CSR: begin
               if (wr_be[0]) begin
                  csr_nxt[CSR_WRAP]                    = wr_data[0];
                  csr_nxt[CSR_IE]                      = wr_data[2];
                  csr_nxt[CSR_ONESHOT]                 = wr_data[3];
                  csr_nxt[CSR_RUN]                     = wr_data[4];
                  csr_nxt[CSR_PRESC_HI:CSR_PRESC_LO]   = wr_data[6:5];
                  if (!wr_data[7]) begin
                     csr_nxt[CSR_EXP] = 1'b0;
                  end
                  if (wr_data[4] && !csr_q[CSR_RUN]) begin
                     cnt_nxt   = reload_q;
                     presc_nxt = '0;
                  end
               end
            end
            default: ;
         endcase
      end

      if (expire) begin
         csr_nxt[CSR_EXP] = 1'b1;
      end

      csr_nxt[1] = 1'b0;
   end

   // Timer register state
   always_ff @(posedge pin_clk or negedge pin_init_n) begin
      if (!pin_init_n) begin
         reload_q <= 16'd0;
         cnt_q    <= 16'd0;
         csr_q    <= 8'd0;
         presc_q  <= '0;
      end else begin
         reload_q <= reload_nxt;
         cnt_q    <= cnt_nxt;
         csr_q    <= csr_nxt;
         presc_q  <= presc_nxt;
      end
   end

   // Interrupt request follows EXP & IE one cycle later
   always_ff @(posedge pin_clk or negedge pin_init_n) begin
      if (!pin_init_n) begin
         irq_q <= 1'b1;
      end else begin
         irq_q <= ~(csr_q[CSR_EXP] & csr_q[CSR_IE]);
      end
   end

   assign reload  = reload_q;
   assign counter = cnt_q;
   assign csr     = csr_q;
   assign irq_n   = irq_q;

endmodule

// File: rtl/bk_sys_timer.sv
// rtl/bk_sys_timer.sv - BK-0011M system timer as an MPI bus responder
module bk_sys_timer
   import bk_bus_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR  = 16'o177706,
   parameter int unsigned BASE_DIV   = 128,
   parameter int unsigned RPLY_DELAY = 0
) (
   input  logic        pin_clk,
   input  logic        pin_init_n,
   input  logic [15:0] pin_ad_in_n,
   output logic [15:0] pin_ad_out_n,
   output logic        pin_ad_oe,
   input  logic        pin_sync_n,
   input  logic        pin_din_n,
   input  logic        pin_dout_n,
   input  logic        pin_wtbt_n,
   output logic        pin_rply_n,
   output logic        pin_irq_n
);

   localparam int unsigned   DW       = (RPLY_DELAY < 1) ? 1 : $clog2(RPLY_DELAY + 1);
   localparam logic [DW-1:0] DLY_LAST = DW'(RPLY_DELAY);

   bus_state_t    state_q, state_nxt;
   logic          sync_q;
   logic [15:0]   addr_q;
   logic [DW-1:0] dly_q, dly_nxt;
   logic          rply_q, rply_nxt;
   logic          oe_q, oe_nxt;
   logic [15:0]   out_q, out_nxt;
   logic          addr_ld;
   logic          wr_en;
   logic [14:0]   offset;
   logic          sel;
   logic [1:0]    reg_idx;
   logic [1:0]    wr_be;
   logic [15:0]   rdata;
   logic [15:0]   reload;
   logic [15:0]   counter;
   logic [7:0]    csr;

   assign offset  = addr_q[15:1] - BASE_ADDR[15:1];
   assign sel     = (offset < 15'd3);
   assign reg_idx = offset[1:0];
   assign wr_be   = pin_wtbt_n ? 2'b11 : (addr_q[0] ? 2'b10 : 2'b01);

   // Read mux; CSR upper byte reads as ones
   always_comb begin
      case (reg_idx)
         REG_RELOAD: rdata = reload;
         REG_COUNT:  rdata = counter;
         default:    rdata = {8'hFF, csr};
      endcase
   end

   // Bus FSM next state and registered bus outputs; SYNC high always aborts
   always_comb begin
      state_nxt = state_q;
      dly_nxt   = dly_q;
      rply_nxt  = rply_q;
      oe_nxt    = oe_q;
      out_nxt   = out_q;
      addr_ld   = 1'b0;
      wr_en     = 1'b0;

      if (pin_sync_n) begin
         state_nxt = BUS_IDLE;
         rply_nxt  = 1'b1;
         oe_nxt    = 1'b0;
         out_nxt   = 16'hFFFF;
      end else begin
         case (state_q)
            BUS_IDLE: begin
               if (sync_q) begin
                  state_nxt = BUS_ADDR;
                  addr_ld   = 1'b1;
               end
            end
            BUS_ADDR: begin
               if (!pin_din_n && sel) begin
                  state_nxt = BUS_RD_WAIT;
                  oe_nxt    = 1'b1;
                  out_nxt   = ~rdata;
                  dly_nxt   = '0;
               end else if (!pin_dout_n && sel) begin
                  state_nxt = BUS_WR_WAIT;
                  wr_en     = 1'b1;
                  dly_nxt   = '0;
               end
            end
            BUS_RD_WAIT: begin
               if (dly_q == DLY_LAST) begin
                  state_nxt = BUS_RD_REPLY;
                  rply_nxt  = 1'b0;
               end else begin
                  dly_nxt = dly_q + DW'(1);
               end
            end
            BUS_RD_REPLY: begin
               if (pin_din_n) begin
                  state_nxt = BUS_END;
                  rply_nxt  = 1'b1;
                  oe_nxt    = 1'b0;
                  out_nxt   = 16'hFFFF;
               end
            end
            BUS_WR_WAIT: begin
               if (dly_q == DLY_LAST) begin
                  state_nxt = BUS_WR_REPLY;
                  rply_nxt  = 1'b0;
               end else begin
                  dly_nxt = dly_q + DW'(1);
               end
            end
            BUS_WR_REPLY: begin
               if (pin_dout_n) begin
                  state_nxt = BUS_END;
                  rply_nxt  = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Bus FSM state, output registers and address latch
   always_ff @(posedge pin_clk or negedge pin_init_n) begin
      if (!pin_init_n) begin
         state_q <= BUS_IDLE;
         sync_q  <= 1'b0;
         addr_q  <= 16'd0;
         dly_q   <= '0;
         rply_q  <= 1'b1;
         oe_q    <= 1'b0;
         out_q   <= 16'hFFFF;
      end else begin
         state_q <= state_nxt;
         sync_q  <= pin_sync_n;
         dly_q   <= dly_nxt;
         rply_q  <= rply_nxt;
         oe_q    <= oe_nxt;
         out_q   <= out_nxt;
         if (addr_ld) begin
            addr_q <= ~pin_ad_in_n;
         end
      end
   end

   bk_timer_core #(
      .BASE_DIV (BASE_DIV)
   ) u_core (
      .pin_clk    (pin_clk),
      .pin_init_n (pin_init_n),
      .wr_en      (wr_en),
      .wr_reg     (reg_idx),
      .wr_data    (~pin_ad_in_n),
      .wr_be      (wr_be),
      .reload     (reload),
      .counter    (counter),
      .csr        (csr),
      .irq_n      (pin_irq_n)
   );

   assign pin_rply_n   = rply_q;
   assign pin_ad_oe    = oe_q;
   assign pin_ad_out_n = out_q;

endmodule

// File: tb/tb_bk_sys_timer.sv
// tb/tb_bk_sys_timer.sv - self-checking bench for bk_sys_timer
module tb_bk_sys_timer;

   localparam logic [15:0] A_RELOAD = 16'o177706;
   localparam logic [15:0] A_CNT    = 16'o177710;
   localparam logic [15:0] A_CSR    = 16'o177712;

   logic        clk = 1'b0;
   logic        init_n = 1'b0;
   logic [15:0] ad_in_n = 16'hFFFF;
   logic        sync_n = 1'b1;
   logic        din_n = 1'b1;
   logic        dout_n = 1'b1;
   logic        wtbt_n = 1'b1;
   logic [15:0] out1, out2;
   logic        oe1, oe2, rply1, rply2, irq1, irq2;

   int cyc = 0;
   int n_checks = 0;
   int n_pass = 0;

   // results of the last bus cycle
   logic [15:0] b_rdata;
   int          b_lat;
   int          b_tk;
   bit          b_rel;
   bit          b_oe_seen;
   logic        b_irq1, b_irq2;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bk_sys_timer #(.BASE_ADDR(16'o177706), .BASE_DIV(4), .RPLY_DELAY(0)) dut (
      .pin_clk(clk), .pin_init_n(init_n), .pin_ad_in_n(ad_in_n), .pin_ad_out_n(out1),
      .pin_ad_oe(oe1), .pin_sync_n(sync_n), .pin_din_n(din_n), .pin_dout_n(dout_n),
      .pin_wtbt_n(wtbt_n), .pin_rply_n(rply1), .pin_irq_n(irq1));

   bk_sys_timer #(.BASE_ADDR(16'o177706), .BASE_DIV(4), .RPLY_DELAY(2)) dut_dly (
      .pin_clk(clk), .pin_init_n(init_n), .pin_ad_in_n(ad_in_n), .pin_ad_out_n(out2),
      .pin_ad_oe(oe2), .pin_sync_n(sync_n), .pin_din_n(din_n), .pin_dout_n(dout_n),
      .pin_wtbt_n(wtbt_n), .pin_rply_n(rply2), .pin_irq_n(irq2));

   // Timer reference: counter/EXP/RUN after n prescaler ticks since RUN was set
   function automatic logic [15:0] model_count(input logic [15:0] r, input bit wrap, input bit os,
                                               input int n, output bit exp, output bit run);
      logic [15:0] c;
      c = r; exp = 1'b0; run = 1'b1;
      for (int i = 0; i < n; i++) begin
         if (run) begin
            if (c != 16'd0) c = c - 16'd1;
            else begin
               exp = 1'b1;
               if (os) begin run = 1'b0; c = 16'd0; end
               else c = wrap ? 16'hFFFF : r;
            end
         end
      end
      return c;
   endfunction

   // One MPI bus cycle; b_lat = negedges from strobe to RPLY low (99 = none)
   task automatic bus_cycle(input bit d2, input bit is_wr, input logic [15:0] addr,
                            input logic [15:0] wdata, input bit bytew);
      @(negedge clk);
      ad_in_n = ~addr; sync_n = 1'b0;
      @(negedge clk);
      if (is_wr) begin ad_in_n = ~wdata; wtbt_n = ~bytew; dout_n = 1'b0; end
      else begin ad_in_n = 16'hFFFF; din_n = 1'b0; end
      b_tk = cyc + 1;
      b_lat = 99; b_oe_seen = 1'b0; b_irq1 = 1'bx; b_irq2 = 1'bx;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (i == 1) b_irq1 = irq1;
         if (i == 2) b_irq2 = irq1;
         if ((d2 ? oe2 : oe1) === 1'b1) b_oe_seen = 1'b1;
         if ((d2 ? rply2 : rply1) === 1'b0) begin b_lat = i; break; end
      end
      b_rdata = ~(d2 ? out2 : out1);
      din_n = 1'b1; dout_n = 1'b1; wtbt_n = 1'b1;
      @(negedge clk);
      b_rel = ((d2 ? rply2 : rply1) === 1'b1) && ((d2 ? oe2 : oe1) === 1'b0);
      sync_n = 1'b1; ad_in_n = 16'hFFFF;
      @(negedge clk);
   endtask

   task automatic rd(input logic [15:0] addr);
      bus_cycle(1'b0, 1'b0, addr, 16'h0000, 1'b0);
   endtask

   task automatic wr(input logic [15:0] addr, input logic [15:0] data);
      bus_cycle(1'b0, 1'b1, addr, data, 1'b0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      init_n = 1'b0; sync_n = 1'b1; din_n = 1'b1; dout_n = 1'b1; wtbt_n = 1'b1; ad_in_n = 16'hFFFF;
      repeat (2) @(negedge clk);
      init_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      init_n = 1'b0;
      #1;
      n_checks++; if (rply1 !== 1'b1) $display("FAIL reset_rply: got %b want 1", rply1); else n_pass++;
      n_checks++; if (oe1 !== 1'b0) $display("FAIL reset_oe: got %b want 0", oe1); else n_pass++;
      n_checks++; if (out1 !== 16'hFFFF) $display("FAIL reset_ad_out: got %h want ffff", out1); else n_pass++;
      n_checks++; if (irq1 !== 1'b1) $display("FAIL reset_irq: got %b want 1", irq1); else n_pass++;
      repeat (2) @(negedge clk);
      init_n = 1'b1;
      @(negedge clk);
      rd(A_CSR);
      n_checks++; if (b_rdata !== 16'hFF00) $display("FAIL reset_csr: got %h want ff00", b_rdata); else n_pass++;
      n_checks++; if (b_lat != 2) $display("FAIL read_latency: got %0d want 2", b_lat); else n_pass++;
      n_checks++; if (!b_rel) $display("FAIL read_release: got 0 want 1"); else n_pass++;
      rd(A_RELOAD);
      n_checks++; if (b_rdata !== 16'h0000) $display("FAIL reset_reload: got %h want 0000", b_rdata); else n_pass++;
      rd(A_CNT);
      n_checks++; if (b_rdata !== 16'h0000) $display("FAIL reset_count: got %h want 0000", b_rdata); else n_pass++;
   endtask

   task automatic test_periodic();
      logic [15:0] r, exp_c;
      logic [1:0]  pr;
      bit          wrapb, m_exp, m_run;
      int          p, t0, n;
      for (int it = 0; it < 4; it++) begin
         r     = (it == 0) ? 16'd3 : 16'($urandom_range(1, 6));
         pr    = (it == 0) ? 2'b00 : ($urandom_range(0, 1) != 0 ? 2'b10 : 2'b00);
         wrapb = (it == 0) ? 1'b0 : 1'($urandom_range(0, 1));
         p     = (pr == 2'b10) ? 16 : 4;
         apply_reset();
         wr(A_RELOAD, r);
         wr(A_CSR, {9'd0, pr, 1'b1, 3'b000, wrapb});
         t0 = b_tk;
         for (int j = 0; j < 5; j++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            rd(A_CNT);
            n = (b_tk - 1 - t0) / p;
            exp_c = model_count(r, wrapb, 1'b0, n, m_exp, m_run);
            n_checks++;
            if (b_rdata !== exp_c) $display("FAIL periodic_count: got %h want %h (r=%0d ticks=%0d)", b_rdata, exp_c, r, n);
            else n_pass++;
         end
         rd(A_CSR);
         n = (b_tk - 1 - t0) / p;
         exp_c = model_count(r, wrapb, 1'b0, n, m_exp, m_run);
         n_checks++;
         if (b_rdata !== {8'hFF, m_exp, pr, m_run, 3'b000, wrapb})
            $display("FAIL periodic_csr: got %h want %h", b_rdata, {8'hFF, m_exp, pr, m_run, 3'b000, wrapb});
         else n_pass++;
         n_checks++; if (irq1 !== 1'b1) $display("FAIL periodic_irq_masked: got %b want 1", irq1); else n_pass++;
      end
   endtask

   task automatic test_oneshot();
      int t0;
      apply_reset();
      wr(A_RELOAD, 16'd1);
      wr(A_CSR, 16'o034);
      t0 = b_tk;
      n_checks++; if (irq1 !== 1'b1) $display("FAIL oneshot_irq_early: got %b want 1", irq1); else n_pass++;
      while (cyc < t0 + 12) @(negedge clk);
      n_checks++; if (irq1 !== 1'b0) $display("FAIL oneshot_irq: got %b want 0", irq1); else n_pass++;
      rd(A_CSR);
      n_checks++; if (b_rdata !== 16'hFF8C) $display("FAIL oneshot_csr: got %h want ff8c", b_rdata); else n_pass++;
      rd(A_CNT);
      n_checks++; if (b_rdata !== 16'h0000) $display("FAIL oneshot_count: got %h want 0000", b_rdata); else n_pass++;
      wr(A_CSR, 16'o004);
      n_checks++; if (b_irq1 !== 1'b0) $display("FAIL exp_clear_irq_hold: got %b want 0", b_irq1); else n_pass++;
      n_checks++; if (b_irq2 !== 1'b1) $display("FAIL exp_clear_irq_release: got %b want 1", b_irq2); else n_pass++;
      rd(A_CSR);
      n_checks++; if (b_rdata !== 16'hFF04) $display("FAIL exp_clear_csr: got %h want ff04", b_rdata); else n_pass++;
   endtask

   task automatic test_wrap_byte();
      int          t0;
      logic [15:0] m_rel, wd;
      logic [7:0]  bv, junk;
      bit          odd;
      apply_reset();
      wr(A_RELOAD, 16'd2);
      wr(A_CSR, 16'o021);
      t0 = b_tk;
      while (cyc < t0 + 12) @(negedge clk);
      rd(A_CNT);
      n_checks++; if (b_rdata !== 16'hFFFF) $display("FAIL wrap_count: got %h want ffff", b_rdata); else n_pass++;
      rd(A_CSR);
      n_checks++; if (b_rdata !== 16'hFF91) $display("FAIL wrap_csr: got %h want ff91", b_rdata); else n_pass++;
      wr(A_CSR, 16'h0000);
      bus_cycle(1'b0, 1'b1, A_RELOAD | 16'd1, 16'hAB00, 1'b1);
      n_checks++; if (b_lat != 2) $display("FAIL byte_write_ack: got %0d want 2", b_lat); else n_pass++;
      rd(A_RELOAD);
      n_checks++; if (b_rdata !== 16'hAB02) $display("FAIL byte_write_hi: got %h want ab02", b_rdata); else n_pass++;
      m_rel = 16'hAB02;
      for (int i = 0; i < 4; i++) begin
         odd  = 1'($urandom_range(0, 1));
         bv   = 8'($urandom);
         junk = 8'($urandom);
         wd   = odd ? {bv, junk} : {junk, bv};
         if (odd) m_rel[15:8] = bv; else m_rel[7:0] = bv;
         bus_cycle(1'b0, 1'b1, A_RELOAD | {15'd0, odd}, wd, 1'b1);
         rd(A_RELOAD);
         n_checks++; if (b_rdata !== m_rel) $display("FAIL byte_write_rand: got %h want %h", b_rdata, m_rel); else n_pass++;
      end
   endtask

   task automatic test_unselected_ro();
      apply_reset();
      rd(16'o177700);
      n_checks++; if (b_lat != 99) $display("FAIL unsel_rply: got lat %0d want none", b_lat); else n_pass++;
      n_checks++; if (b_oe_seen) $display("FAIL unsel_oe: got 1 want 0"); else n_pass++;
      bus_cycle(1'b0, 1'b1, 16'o177714, 16'($urandom), 1'b0);
      n_checks++; if (b_lat != 99) $display("FAIL unsel_above_rply: got lat %0d want none", b_lat); else n_pass++;
      wr(A_RELOAD, 16'h1234);
      wr(A_CSR, 16'h0070);
      wr(A_CSR, 16'h0060);
      wr(A_CNT, 16'hBEEF);
      n_checks++; if (b_lat != 2) $display("FAIL count_write_ack: got %0d want 2", b_lat); else n_pass++;
      rd(A_CNT);
      n_checks++; if (b_rdata !== 16'h1234) $display("FAIL count_readonly: got %h want 1234", b_rdata); else n_pass++;
      rd(A_CSR);
      n_checks++; if (b_rdata !== 16'hFF60) $display("FAIL stopped_csr: got %h want ff60", b_rdata); else n_pass++;
   endtask

   task automatic test_rply_delay();
      logic [15:0] v;
      apply_reset();
      bus_cycle(1'b1, 1'b0, A_CSR, 16'h0000, 1'b0);
      n_checks++; if (b_lat != 4) $display("FAIL delay_read_lat: got %0d want 4", b_lat); else n_pass++;
      n_checks++; if (b_rdata !== 16'hFF00) $display("FAIL delay_read_data: got %h want ff00", b_rdata); else n_pass++;
      v = 16'($urandom);
      bus_cycle(1'b1, 1'b1, A_RELOAD, v, 1'b0);
      n_checks++; if (b_lat != 4) $display("FAIL delay_write_lat: got %0d want 4", b_lat); else n_pass++;
      n_checks++; if (!b_rel) $display("FAIL delay_write_release: got 0 want 1"); else n_pass++;
      rd(A_RELOAD);
      n_checks++; if (b_rdata !== v) $display("FAIL delay_write_data: got %h want %h", b_rdata, v); else n_pass++;
   endtask

   task automatic test_reset_midcycle();
      bit got;
      apply_reset();
      wr(A_RELOAD, 16'h5A5A);
      wr(A_CSR, 16'o024);
      @(negedge clk);
      ad_in_n = ~A_CNT; sync_n = 1'b0;
      @(negedge clk);
      ad_in_n = 16'hFFFF; din_n = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rply1 === 1'b0) begin got = 1'b1; break; end
      end
      n_checks++; if (!got) $display("FAIL midreset_reply: got none want rply"); else n_pass++;
      #2 init_n = 1'b0;
      #1;
      n_checks++; if (rply1 !== 1'b1) $display("FAIL midreset_rply: got %b want 1", rply1); else n_pass++;
      n_checks++; if (oe1 !== 1'b0) $display("FAIL midreset_oe: got %b want 0", oe1); else n_pass++;
      n_checks++; if (out1 !== 16'hFFFF) $display("FAIL midreset_ad_out: got %h want ffff", out1); else n_pass++;
      @(negedge clk);
      din_n = 1'b1; sync_n = 1'b1;
      @(negedge clk);
      init_n = 1'b1;
      @(negedge clk);
      rd(A_RELOAD);
      n_checks++; if (b_rdata !== 16'h0000) $display("FAIL midreset_reload: got %h want 0000", b_rdata); else n_pass++;
      rd(A_CNT);
      n_checks++; if (b_rdata !== 16'h0000) $display("FAIL midreset_count: got %h want 0000", b_rdata); else n_pass++;
      rd(A_CSR);
      n_checks++; if (b_rdata !== 16'hFF00) $display("FAIL midreset_csr: got %h want ff00", b_rdata); else n_pass++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_periodic();
      test_oneshot();
      test_wrap_byte();
      test_unselected_ro();
      test_rply_delay();
      test_reset_midcycle();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
